// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core run controller: FSM states, halt causes and
// the trap opcodes that stop execution.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StBoot = 3'd1,
    StRun  = 3'd2,
    StStep = 3'd3,
    StHalt = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    CauseNone  = 2'd0,
    CauseStop  = 2'd1,
    CauseTrap  = 2'd2,
    CauseLimit = 2'd3
  } halt_cause_e;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  function automatic logic is_trap(input logic [31:0] instr);
    return (instr == InstrEcall) || (instr == InstrEbreak);
  endfunction

endpackage

// File: rtl/core_run_ctrl.sv
// Boot/run/single-step/halt sequencer for a core: gates commit enable, counts
// enabled cycles and records why and where the core stopped.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned ARCH_WIDTH = 64,
  parameter int unsigned BOOT_HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step_mode,
  input  logic                  step_req,
  output logic                  step_ack,
  input  logic [ARCH_WIDTH-1:0] cycle_limit,
  input  logic [31:0]           instruction,
  input  logic [ARCH_WIDTH-1:0] pc,
  output logic                  core_en,
  output logic                  core_rst,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic [ARCH_WIDTH-1:0] halt_pc,
  output logic [ARCH_WIDTH-1:0] cycle_count
);

  localparam logic [3:0] BootHold = 4'(BOOT_HOLD);
  localparam logic [ARCH_WIDTH-1:0] CountOne = {{(ARCH_WIDTH-1){1'b0}}, 1'b1};

  run_state_e            state_q, state_d;
  halt_cause_e           halt_cause_q, halt_cause_d;
  logic [ARCH_WIDTH-1:0] halt_pc_q, halt_pc_d;
  logic [ARCH_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [3:0]            boot_cnt_q, boot_cnt_d;
  logic                  step_busy_q, step_busy_d;
  logic                  step_ack_q, step_ack_d;

  logic        trap, limit_hit, halt_evt;
  halt_cause_e cause_sel;

  assign trap      = is_trap(instruction);
  assign limit_hit = (cycle_limit != '0) && (cycle_count_q == cycle_limit);
  assign halt_evt  = stop || trap || limit_hit;
  assign cause_sel = stop ? CauseStop : (trap ? CauseTrap : CauseLimit);

  always_comb begin
    state_d       = state_q;
    halt_cause_d  = halt_cause_q;
    halt_pc_d     = halt_pc_q;
    cycle_count_d = cycle_count_q;
    boot_cnt_d    = boot_cnt_q;
    step_busy_d   = step_busy_q;
    step_ack_d    = 1'b0;
    core_en       = 1'b0;
    core_rst      = 1'b0;

    // The step handshake closes once the requester drops step_req.
    if (step_busy_q && !step_req) step_busy_d = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        core_rst = (state_q == StIdle);
        if (start) begin
          state_d       = StBoot;
          cycle_count_d = '0;
          halt_cause_d  = CauseNone;
          boot_cnt_d    = BootHold;
          step_busy_d   = 1'b0;
        end
      end
      StBoot: begin
        core_rst = 1'b1;
        if (boot_cnt_q <= 4'd1) begin
          boot_cnt_d = '0;
          state_d    = step_mode ? StStep : StRun;
        end else begin
          boot_cnt_d = boot_cnt_q - 4'd1;
        end
      end
      StRun, StStep: begin
        if (halt_evt) begin
          state_d      = StHalt;
          halt_cause_d = cause_sel;
          halt_pc_d    = pc;
        end else if (state_q == StRun) begin
          core_en = 1'b1;
        end else if (step_req && !step_busy_q) begin
          core_en     = 1'b1;
          step_ack_d  = 1'b1;
          step_busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (core_en) cycle_count_d = cycle_count_q + CountOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      halt_cause_q  <= CauseNone;
      halt_pc_q     <= '0;
      cycle_count_q <= '0;
      boot_cnt_q    <= '0;
      step_busy_q   <= 1'b0;
      step_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_cause_q  <= halt_cause_d;
      halt_pc_q     <= halt_pc_d;
      cycle_count_q <= cycle_count_d;
      boot_cnt_q    <= boot_cnt_d;
      step_busy_q   <= step_busy_d;
      step_ack_q    <= step_ack_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == StHalt);
  assign halt_cause  = halt_cause_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cycle_count_q;
  assign step_ack    = step_ack_q;

endmodule
